// File: rtl/result_buffer_ctrl_pkg.sv
// Shared types and sizes for the value-skip result buffer.
//   RESULT_BUFFER_SIZE    - number of result-buffer slots (power of two)
//   RESULT_BUFFER_ID_SIZE - width of a slot index
//   data32b               - 32-bit result word
//   RbIdxType             - slot index
//   ResultBufferEntryType - {result, valid} as seen by the skip-table lookup
package result_buffer_ctrl_pkg;

    localparam int unsigned RESULT_BUFFER_SIZE    = 8;
    localparam int unsigned RESULT_BUFFER_ID_SIZE = 3;

    typedef logic [31:0]                      data32b;
    typedef logic [RESULT_BUFFER_ID_SIZE-1:0] RbIdxType;

    typedef struct packed {
        data32b result;
        logic   valid;
    } ResultBufferEntryType;

endpackage

// File: rtl/result_buffer_ctrl_rb_ptr_ctrl.sv
// Head/tail/count bookkeeping for the result buffer.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   alloc_req    - request one slot
//   retire_en    - free the head slot
//   flush        - discard everything (head=tail=count=0)
//   alloc_grant  - alloc_req accepted this cycle (uses registered count)
//   retire_ok    - retire_en accepted this cycle (buffer not empty)
//   head_idx     - oldest allocated slot
//   tail_idx     - next slot to allocate
//   full, empty  - count == RB_SIZE / count == 0
module rb_ptr_ctrl #(
    parameter int unsigned RB_SIZE = 8,
    parameter int unsigned RB_ID_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_req,
    input  logic               retire_en,
    input  logic               flush,
    output logic               alloc_grant,
    output logic               retire_ok,
    output logic [RB_ID_W-1:0] head_idx,
    output logic [RB_ID_W-1:0] tail_idx,
    output logic               full,
    output logic               empty
);

    // One extra bit so count can represent RB_SIZE itself.
    localparam logic [RB_ID_W:0] CountMax = (RB_ID_W + 1)'(RB_SIZE);

    logic [RB_ID_W-1:0] head_q, head_d;
    logic [RB_ID_W-1:0] tail_q, tail_d;
    logic [RB_ID_W:0]   count_q, count_d;

    assign full        = (count_q == CountMax);
    assign empty       = (count_q == '0);
    assign alloc_grant = alloc_req & ~full;
    assign retire_ok   = retire_en & ~empty;
    assign head_idx    = head_q;
    assign tail_idx    = tail_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers wrap naturally since RB_SIZE is a power of two.
            if (retire_ok)   head_d = head_q + RB_ID_W'(1);
            if (alloc_grant) tail_d = tail_q + RB_ID_W'(1);
            unique case ({alloc_grant, retire_ok})
                2'b10:   count_d = count_q + (RB_ID_W + 1)'(1);
                2'b01:   count_d = count_q - (RB_ID_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/result_buffer_ctrl.sv
// Value-skip result buffer: allocates slots in order, captures writeback
// results, and serves two combinational lookups (with writeback bypass) to
// the skip-table stage.
// Ports:
//   clk, rst                - clock, synchronous active-high reset
//   alloc_req/alloc_grant   - slot request / combinational grant
//   alloc_idx               - index of the granted slot (tail)
//   wb_en/wb_idx/wb_data    - result writeback
//   retire_en/head_idx      - free oldest slot / oldest slot index
//   flush                   - drop all slots (results kept, but invalid)
//   rd1_idx/rd1_entry       - rs1 lookup
//   rd2_idx/rd2_entry       - rs2 lookup
//   full, empty             - occupancy flags
//   wb_err                  - registered pulse: writeback to unallocated slot
module result_buffer_ctrl
    import result_buffer_ctrl_pkg::*;
#(
    parameter int unsigned RB_SIZE = RESULT_BUFFER_SIZE,
    parameter int unsigned RB_ID_W = RESULT_BUFFER_ID_SIZE,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_grant,
    output logic [RB_ID_W-1:0]   alloc_idx,
    input  logic                 wb_en,
    input  logic [RB_ID_W-1:0]   wb_idx,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 retire_en,
    output logic [RB_ID_W-1:0]   head_idx,
    input  logic                 flush,
    input  logic [RB_ID_W-1:0]   rd1_idx,
    input  logic [RB_ID_W-1:0]   rd2_idx,
    output ResultBufferEntryType rd1_entry,
    output ResultBufferEntryType rd2_entry,
    output logic                 full,
    output logic                 empty,
    output logic                 wb_err
);

    logic               retire_ok;
    logic [RB_ID_W-1:0] tail_idx;
    logic               wb_hit;

    logic [RB_SIZE-1:0] alloc_q, alloc_d;
    logic [RB_SIZE-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]  result_q [RB_SIZE];
    logic [DATA_W-1:0]  result_d [RB_SIZE];
    logic               wb_err_q, wb_err_d;

    rb_ptr_ctrl #(
        .RB_SIZE (RB_SIZE),
        .RB_ID_W (RB_ID_W)
    ) u_ptr (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .retire_en   (retire_en),
        .flush       (flush),
        .alloc_grant (alloc_grant),
        .retire_ok   (retire_ok),
        .head_idx    (head_idx),
        .tail_idx    (tail_idx),
        .full        (full),
        .empty       (empty)
    );

    assign alloc_idx = tail_idx;
    assign wb_err    = wb_err_q;
    assign wb_hit    = wb_en & alloc_q[wb_idx];

    always_comb begin
        alloc_d  = alloc_q;
        valid_d  = valid_q;
        result_d = result_q;
        wb_err_d = 1'b0;
        if (flush) begin
            alloc_d = '0;
            valid_d = '0;
        end else begin
            if (alloc_grant) begin
                alloc_d[tail_idx] = 1'b1;
                valid_d[tail_idx] = 1'b0;
            end
            // Uses registered alloc, so a slot granted this cycle flags an error.
            if (wb_en) begin
                if (alloc_q[wb_idx]) begin
                    result_d[wb_idx] = wb_data;
                    valid_d[wb_idx]  = 1'b1;
                end else begin
                    wb_err_d = 1'b1;
                end
            end
            // Applied last so retire beats a same-cycle writeback to the head.
            if (retire_ok) begin
                alloc_d[head_idx] = 1'b0;
                valid_d[head_idx] = 1'b0;
            end
        end
    end

    always_comb begin
        if (wb_hit && (wb_idx == rd1_idx)) begin
            rd1_entry = '{result: data32b'(wb_data), valid: 1'b1};
        end else begin
            rd1_entry = '{result: data32b'(result_q[rd1_idx]),
                          valid:  valid_q[rd1_idx] & alloc_q[rd1_idx]};
        end
        if (wb_hit && (wb_idx == rd2_idx)) begin
            rd2_entry = '{result: data32b'(wb_data), valid: 1'b1};
        end else begin
            rd2_entry = '{result: data32b'(result_q[rd2_idx]),
                          valid:  valid_q[rd2_idx] & alloc_q[rd2_idx]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q  <= '0;
            valid_q  <= '0;
            wb_err_q <= 1'b0;
            for (int i = 0; i < int'(RB_SIZE); i++) begin
                result_q[i] <= '0;
            end
        end else begin
            alloc_q  <= alloc_d;
            valid_q  <= valid_d;
            wb_err_q <= wb_err_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_result_buffer_ctrl.sv
// Directed bench for result_buffer_ctrl with hand-computed expectations.
module tb_result_buffer_ctrl;
    import result_buffer_ctrl_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 alloc_req;
    logic                 alloc_grant;
    logic [2:0]           alloc_idx;
    logic                 wb_en;
    logic [2:0]           wb_idx;
    logic [31:0]          wb_data;
    logic                 retire_en;
    logic [2:0]           head_idx;
    logic                 flush;
    logic [2:0]           rd1_idx;
    logic [2:0]           rd2_idx;
    ResultBufferEntryType rd1_entry;
    ResultBufferEntryType rd2_entry;
    logic                 full;
    logic                 empty;
    logic                 wb_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    result_buffer_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_grant (alloc_grant),
        .alloc_idx   (alloc_idx),
        .wb_en       (wb_en),
        .wb_idx      (wb_idx),
        .wb_data     (wb_data),
        .retire_en   (retire_en),
        .head_idx    (head_idx),
        .flush       (flush),
        .rd1_idx     (rd1_idx),
        .rd2_idx     (rd2_idx),
        .rd1_entry   (rd1_entry),
        .rd2_entry   (rd2_entry),
        .full        (full),
        .empty       (empty),
        .wb_err      (wb_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req = 1'b0;
        wb_en     = 1'b0;
        wb_idx    = '0;
        wb_data   = '0;
        retire_en = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rd1_idx = '0;
        rd2_idx = '0;
        rst     = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_empty", 64'(empty), 64'd1);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_grant", 64'(alloc_grant), 64'd0);
        check_eq("rst_head", 64'(head_idx), 64'd0);
        check_eq("rst_tail", 64'(alloc_idx), 64'd0);
        check_eq("rst_wb_err", 64'(wb_err), 64'd0);

        // Fill all eight slots back to back.
        for (int i = 0; i < 8; i++) begin
            alloc_req = 1'b1;
            #1;
            check_eq($sformatf("fill_grant%0d", i), 64'(alloc_grant), 64'd1);
            check_eq($sformatf("fill_idx%0d", i), 64'(alloc_idx), 64'(i));
            step();
        end
        #1;
        check_eq("full_grant", 64'(alloc_grant), 64'd0);
        check_eq("full_flag", 64'(full), 64'd1);
        check_eq("full_tail", 64'(alloc_idx), 64'd0);

        // Full: alloc and retire together -> no grant, head advances, count 7.
        retire_en = 1'b1;
        #1;
        check_eq("fullret_grant", 64'(alloc_grant), 64'd0);
        step();
        retire_en = 1'b0;
        #1;
        check_eq("fullret_head", 64'(head_idx), 64'd1);
        check_eq("fullret_notfull", 64'(full), 64'd0);
        check_eq("wrap_grant", 64'(alloc_grant), 64'd1);
        check_eq("wrap_idx", 64'(alloc_idx), 64'd0);
        step();
        alloc_req = 1'b0;
        #1;
        check_eq("wrap_full", 64'(full), 64'd1);

        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check_eq("flush1_empty", 64'(empty), 64'd1);
        check_eq("flush1_head", 64'(head_idx), 64'd0);

        // Allocate slot 0, look it up before and after writeback.
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        rd1_idx   = 3'd0;
        #1;
        check_eq("lk_unwritten", 64'(rd1_entry.valid), 64'd0);
        wb_en   = 1'b1;
        wb_idx  = 3'd0;
        wb_data = 32'hDEAD_BEEF;
        #1;
        check_eq("lk_bypass", 64'(rd1_entry), {31'd0, 32'hDEAD_BEEF, 1'b1});
        step();
        wb_en = 1'b0;
        #1;
        check_eq("lk_stored", 64'(rd1_entry), {31'd0, 32'hDEAD_BEEF, 1'b1});
        check_eq("lk_no_err", 64'(wb_err), 64'd0);

        // Slot 1 allocated (count 2), then writeback slot 0 while it retires.
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        wb_en     = 1'b1;
        wb_idx    = 3'd0;
        wb_data   = 32'h0BAD_F00D;
        retire_en = 1'b1;
        step();
        wb_en     = 1'b0;
        retire_en = 1'b0;
        #1;
        check_eq("wbret_invalid", 64'(rd1_entry.valid), 64'd0);
        check_eq("wbret_head", 64'(head_idx), 64'd1);
        check_eq("wbret_notempty", 64'(empty), 64'd0);
        retire_en = 1'b1;
        step();
        retire_en = 1'b0;
        #1;
        check_eq("wbret_count1", 64'(empty), 64'd1);

        // Writeback to unallocated slot 5.
        wb_en   = 1'b1;
        wb_idx  = 3'd5;
        wb_data = 32'h1234;
        rd2_idx = 3'd5;
        #1;
        check_eq("uwb_no_bypass", 64'(rd2_entry.valid), 64'd0);
        check_eq("uwb_err_pre", 64'(wb_err), 64'd0);
        step();
        wb_en = 1'b0;
        #1;
        check_eq("uwb_err_pulse", 64'(wb_err), 64'd1);
        check_eq("uwb_rd2_invalid", 64'(rd2_entry.valid), 64'd0);
        check_eq("uwb_rd2_data", 64'(rd2_entry.result), 64'd0);
        check_eq("uwb_still_empty", 64'(empty), 64'd1);
        step();
        check_eq("uwb_err_cleared", 64'(wb_err), 64'd0);

        // Four slots, two valid, then flush with alloc_req held.
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alloc_req = 1'b1;
            step();
        end
        alloc_req = 1'b0;
        wb_en     = 1'b1;
        wb_idx    = 3'd0;
        wb_data   = 32'hA0;
        step();
        wb_idx  = 3'd2;
        wb_data = 32'hA2;
        step();
        wb_en   = 1'b0;
        rd1_idx = 3'd0;
        rd2_idx = 3'd2;
        #1;
        check_eq("pre_flush_rd1", 64'(rd1_entry), {31'd0, 32'hA0, 1'b1});
        check_eq("pre_flush_rd2", 64'(rd2_entry), {31'd0, 32'hA2, 1'b1});
        check_eq("pre_flush_tail", 64'(alloc_idx), 64'd4);
        flush     = 1'b1;
        alloc_req = 1'b1;
        step();
        flush     = 1'b0;
        alloc_req = 1'b0;
        #1;
        check_eq("flush_empty", 64'(empty), 64'd1);
        check_eq("flush_head", 64'(head_idx), 64'd0);
        check_eq("flush_tail", 64'(alloc_idx), 64'd0);
        check_eq("flush_rd1", 64'(rd1_entry.valid), 64'd0);
        check_eq("flush_rd2", 64'(rd2_entry.valid), 64'd0);

        // Reset mid-allocation, with an error-causing writeback in the same cycle.
        alloc_req = 1'b1;
        step();
        step();
        rst     = 1'b1;
        wb_en   = 1'b1;
        wb_idx  = 3'd7;
        wb_data = 32'h77;
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        check_eq("mrst_empty", 64'(empty), 64'd1);
        check_eq("mrst_full", 64'(full), 64'd0);
        check_eq("mrst_head", 64'(head_idx), 64'd0);
        check_eq("mrst_tail", 64'(alloc_idx), 64'd0);
        check_eq("mrst_wb_err", 64'(wb_err), 64'd0);
        check_eq("mrst_grant", 64'(alloc_grant), 64'd0);
        check_eq("mrst_rd1", 64'(rd1_entry), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
